// File: rtl/text_banner_rom_if.sv
// Banner text request/response bundle between the character address generator and the banner ROM.
// master drives the column/message request; slave returns the registered character code.
interface text_banner_rom_if #(
  parameter int COLS      = 16,
  parameter int MSG_COUNT = 4
);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MSG_W = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1;

  logic             frame_tick;
  logic [MSG_W-1:0] msg_sel;
  logic             blink_en;
  logic [COL_W-1:0] char_x;
  logic [6:0]       char_code;
  logic [MSG_W-1:0] msg_active;

  modport master (
    output frame_tick, msg_sel, blink_en, char_x,
    input  char_code, msg_active
  );

  modport slave (
    input  frame_tick, msg_sel, blink_en, char_x,
    output char_code, msg_active
  );
endinterface

// File: rtl/text_banner_rom.sv
// Registered multi-message banner text source with frame-synchronous message switch and blinking.
// Define TEXT_BANNER_SCROLL_EN to rotate the text left one column every SCROLL_FRAMES frames.
module text_banner_rom #(
  parameter int COLS          = 16,
  parameter int MSG_COUNT     = 4,
  parameter int BLINK_FRAMES  = 30,
  parameter int SCROLL_FRAMES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  text_banner_rom_if.slave  bus
);
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MSG_W   = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0]   BLANK = 7'h20;
  localparam logic [127:0] MSG0  = "START       GAME";
  localparam logic [127:0] MSG1  = "PLAYER 1 WINS!  ";
  localparam logic [127:0] MSG2  = "PLAYER 2 WINS!  ";
  localparam logic [127:0] MSG3  = "PAUSED          ";

  logic [6:0]         r_char_code;
  logic [MSG_W-1:0]   r_msg_active;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_vis;

  logic               w_restart;
  logic [COL_W-1:0]   w_scroll_off;
  logic [COL_W:0]     w_sum;
  logic [COL_W:0]     w_col;
  logic               w_x_oob;
  logic               w_hide;
  logic [6:0]         w_glyph;

  // Stored strings are 16 characters; anything past that, or an unknown id, reads blank.
  function automatic logic [6:0] f_glyph(input logic [MSG_W-1:0] msg, input logic [COL_W:0] col);
    logic [127:0] row;
    int unsigned  c;
    row = {16{8'h20}};
    if (int'(msg) < MSG_COUNT) begin
      case (int'(msg))
        0:       row = MSG0;
        1:       row = MSG1;
        2:       row = MSG2;
        3:       row = MSG3;
        default: row = {16{8'h20}};
      endcase
    end
    c = int'(col);
    if (c < 16) return row[8*(15-c) +: 7];
    return BLANK;
  endfunction

  assign w_restart = bus.frame_tick && (bus.msg_sel != r_msg_active);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msg_active <= '0;
    end else if (w_restart) begin
      r_msg_active <= bus.msg_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_blink_vis <= 1'b1;
    end else if (w_restart) begin
      r_blink_cnt <= '0;
      r_blink_vis <= 1'b1;
    end else if (bus.frame_tick) begin
      if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_vis <= ~r_blink_vis;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

`ifdef TEXT_BANNER_SCROLL_EN
  localparam int SCROLL_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  logic [SCROLL_W-1:0] r_scroll_cnt;
  logic [COL_W-1:0]    r_scroll_off;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scroll_cnt <= '0;
      r_scroll_off <= '0;
    end else if (w_restart) begin
      r_scroll_cnt <= '0;
      r_scroll_off <= '0;
    end else if (bus.frame_tick) begin
      if (r_scroll_cnt == SCROLL_W'(SCROLL_FRAMES - 1)) begin
        r_scroll_cnt <= '0;
        r_scroll_off <= (r_scroll_off == COL_W'(COLS - 1)) ? '0 : r_scroll_off + 1'b1;
      end else begin
        r_scroll_cnt <= r_scroll_cnt + 1'b1;
      end
    end
  end

  assign w_scroll_off = r_scroll_off;
`else
  assign w_scroll_off = '0;
`endif

  // Modular wrap by subtraction keeps non-power-of-2 row widths correct.
  always_comb begin
    w_sum = {1'b0, bus.char_x} + {1'b0, w_scroll_off};
    w_col = (w_sum >= (COL_W+1)'(COLS)) ? w_sum - (COL_W+1)'(COLS) : w_sum;
  end

  assign w_x_oob = ({1'b0, bus.char_x} >= (COL_W+1)'(COLS));
  assign w_hide  = bus.blink_en && !r_blink_vis;
  assign w_glyph = f_glyph(r_msg_active, w_col);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_char_code <= BLANK;
    end else begin
      r_char_code <= (w_x_oob || w_hide) ? BLANK : w_glyph;
    end
  end

  assign bus.char_code  = r_char_code;
  assign bus.msg_active = r_msg_active;
endmodule

// File: tb/tb_text_banner_rom.sv
// Directed self-checking bench for text_banner_rom with a 20-column row and 2-frame blink period.
// Expected characters are hand-decoded from the fixed message strings.
module tb_text_banner_rom;
  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  text_banner_rom_if #(.COLS(20), .MSG_COUNT(4)) bus ();

  text_banner_rom #(
    .COLS(20),
    .MSG_COUNT(4),
    .BLINK_FRAMES(2),
    .SCROLL_FRAMES(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
  endtask

  // Column to drive so that the looked-up text column is col after the given tick count.
  function automatic logic [4:0] xcol(input int col, input int ticks);
    int off;
`ifdef TEXT_BANNER_SCROLL_EN
    off = ticks % 20;
`else
    off = 0;
`endif
    return 5'((col + 20 - off) % 20);
  endfunction

  task automatic do_reset();
    reset_n        = 1'b0;
    bus.frame_tick = 1'b0;
    bus.msg_sel    = '0;
    bus.blink_en   = 1'b0;
    bus.char_x     = '0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    bus.frame_tick = 1'($urandom_range(0, 1));
    bus.msg_sel    = 2'($urandom_range(0, 3));
    bus.blink_en   = 1'($urandom_range(0, 1));
    bus.char_x     = 5'($urandom_range(0, 19));
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (bus.char_code !== 7'h20) begin bad++; $display("FAIL reset_code got=%h exp=20", bus.char_code); end
    total++; if (bus.msg_active !== 2'd0) begin bad++; $display("FAIL reset_msg got=%0d exp=0", bus.msg_active); end
    repeat (3) cyc();
    bus.frame_tick = 1'b0;
    bus.msg_sel    = 2'd2;
    bus.blink_en   = 1'b0;
    bus.char_x     = 5'd0;
    reset_n        = 1'b1;
    frame();
    cyc();
    total++; if (bus.char_code !== 7'h50) begin bad++; $display("FAIL pre_reset_code got=%h exp=50", bus.char_code); end
    total++; if (bus.msg_active !== 2'd2) begin bad++; $display("FAIL pre_reset_msg got=%0d exp=2", bus.msg_active); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (bus.char_code !== 7'h20) begin bad++; $display("FAIL async_reset_code got=%h exp=20", bus.char_code); end
    total++; if (bus.msg_active !== 2'd0) begin bad++; $display("FAIL async_reset_msg got=%0d exp=0", bus.msg_active); end
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_lookup();
    logic [4:0] xs  [7] = '{5'd0, 5'd12, 5'd5, 5'd15, 5'd3, 5'd17, 5'd19};
    logic [6:0] exp [7] = '{7'h53, 7'h47, 7'h20, 7'h45, 7'h52, 7'h20, 7'h20};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.char_x = xs[i];
      cyc();
      total++;
      if (bus.char_code !== exp[i]) begin
        bad++; $display("FAIL lookup x=%0d got=%h exp=%h", xs[i], bus.char_code, exp[i]);
      end
    end
  endtask

  task automatic test_msg_latch();
    do_reset();
    bus.msg_sel = 2'd1;
    bus.char_x  = 5'd0;
    repeat (3) cyc();
    total++; if (bus.char_code !== 7'h53) begin bad++; $display("FAIL no_tick_code got=%h exp=53", bus.char_code); end
    total++; if (bus.msg_active !== 2'd0) begin bad++; $display("FAIL no_tick_msg got=%0d exp=0", bus.msg_active); end
    bus.frame_tick = 1'b1;
    bus.char_x     = 5'd1;
    cyc();
    total++; if (bus.char_code !== 7'h54) begin bad++; $display("FAIL tick_edge_code got=%h exp=54", bus.char_code); end
    total++; if (bus.msg_active !== 2'd1) begin bad++; $display("FAIL tick_msg got=%0d exp=1", bus.msg_active); end
    bus.frame_tick = 1'b0;
    bus.char_x     = 5'd7;
    cyc();
    total++; if (bus.char_code !== 7'h31) begin bad++; $display("FAIL msg1_x7 got=%h exp=31", bus.char_code); end
    bus.char_x = 5'd13;
    cyc();
    total++; if (bus.char_code !== 7'h21) begin bad++; $display("FAIL msg1_x13 got=%h exp=21", bus.char_code); end
    bus.msg_sel = 2'd2;
    frame();
    bus.char_x = 5'd7;
    cyc();
    total++; if (bus.char_code !== 7'h32) begin bad++; $display("FAIL msg2_x7 got=%h exp=32", bus.char_code); end
    bus.msg_sel = 2'd3;
    frame();
    bus.char_x = 5'd5;
    cyc();
    total++; if (bus.char_code !== 7'h44) begin bad++; $display("FAIL msg3_x5 got=%h exp=44", bus.char_code); end
  endtask

  task automatic test_blink();
    do_reset();
    bus.blink_en = 1'b1;
    frame();
    bus.char_x = xcol(0, 1);
    cyc();
    total++; if (bus.char_code !== 7'h53) begin bad++; $display("FAIL blink_t1 got=%h exp=53", bus.char_code); end
    frame();
    bus.char_x = xcol(0, 2);
    cyc();
    total++; if (bus.char_code !== 7'h20) begin bad++; $display("FAIL blink_t2 got=%h exp=20", bus.char_code); end
    frame();
    frame();
    bus.char_x = xcol(0, 4);
    cyc();
    total++; if (bus.char_code !== 7'h53) begin bad++; $display("FAIL blink_t4 got=%h exp=53", bus.char_code); end
    frame();
    frame();
    bus.char_x = xcol(0, 6);
    cyc();
    total++; if (bus.char_code !== 7'h20) begin bad++; $display("FAIL blink_t6 got=%h exp=20", bus.char_code); end
    bus.blink_en = 1'b0;
    cyc();
    total++; if (bus.char_code !== 7'h53) begin bad++; $display("FAIL blink_off got=%h exp=53", bus.char_code); end
    bus.blink_en   = 1'b1;
    bus.msg_sel    = 2'd3;
    bus.frame_tick = 1'b1;
    cyc();
    total++; if (bus.char_code !== 7'h20) begin bad++; $display("FAIL restart_edge got=%h exp=20", bus.char_code); end
    bus.frame_tick = 1'b0;
    bus.char_x     = 5'd0;
    cyc();
    total++; if (bus.char_code !== 7'h50) begin bad++; $display("FAIL restart_visible got=%h exp=50", bus.char_code); end
  endtask

`ifdef TEXT_BANNER_SCROLL_EN
  task automatic test_scroll();
    do_reset();
    frame();
    bus.char_x = 5'd0;
    cyc();
    total++; if (bus.char_code !== 7'h54) begin bad++; $display("FAIL scroll1_x0 got=%h exp=54", bus.char_code); end
    bus.char_x = 5'd19;
    cyc();
    total++; if (bus.char_code !== 7'h53) begin bad++; $display("FAIL scroll1_x19 got=%h exp=53", bus.char_code); end
    repeat (15) frame();
    bus.char_x = 5'd0;
    cyc();
    total++; if (bus.char_code !== 7'h20) begin bad++; $display("FAIL scroll16_x0 got=%h exp=20", bus.char_code); end
    bus.char_x = 5'd4;
    cyc();
    total++; if (bus.char_code !== 7'h53) begin bad++; $display("FAIL scroll16_x4 got=%h exp=53", bus.char_code); end
    bus.msg_sel = 2'd1;
    frame();
    bus.char_x = 5'd0;
    cyc();
    total++; if (bus.char_code !== 7'h50) begin bad++; $display("FAIL scroll_restart got=%h exp=50", bus.char_code); end
  endtask
`else
  task automatic test_static();
    do_reset();
    repeat (3) frame();
    bus.char_x = 5'd0;
    cyc();
    total++; if (bus.char_code !== 7'h53) begin bad++; $display("FAIL static_x0 got=%h exp=53", bus.char_code); end
    bus.char_x = 5'd1;
    cyc();
    total++; if (bus.char_code !== 7'h54) begin bad++; $display("FAIL static_x1 got=%h exp=54", bus.char_code); end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    bus.blink_en = 1'b1;
    bus.msg_sel  = 2'd1;
    frame();
    frame();
    frame();
    bus.char_x = 5'd0;
    cyc();
    total++; if (bus.char_code !== 7'h20) begin bad++; $display("FAIL mid_hidden got=%h exp=20", bus.char_code); end
    reset_n     = 1'b0;
    bus.msg_sel = 2'd0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    total++; if (bus.msg_active !== 2'd0) begin bad++; $display("FAIL mid_reset_msg got=%0d exp=0", bus.msg_active); end
    total++; if (bus.char_code !== 7'h53) begin bad++; $display("FAIL mid_reset_x0 got=%h exp=53", bus.char_code); end
    bus.char_x = 5'd1;
    cyc();
    total++; if (bus.char_code !== 7'h54) begin bad++; $display("FAIL mid_reset_x1 got=%h exp=54", bus.char_code); end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.msg_sel    = '0;
    bus.blink_en   = 1'b0;
    bus.char_x     = '0;
    test_reset();
    test_lookup();
    test_msg_latch();
    test_blink();
`ifdef TEXT_BANNER_SCROLL_EN
    test_scroll();
`else
    test_static();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
